// File: rtl/ndp_core_arbiter_if.sv
// Bundle of requester-side and core-side signals around the NDP core arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the environment (requesters plus the NDP core) that drives it.
interface ndp_core_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   // Requester side
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        req_ack;
   logic [NUM_REQ-1:0]        done;
   logic [NUM_REQ-1:0]        err;

   // Core side
   logic                      core_reset;
   logic                      core_data_in_flag;
   logic [DATA_W-1:0]         core_data_in;
   logic                      core_data_read_flag;
   logic                      core_calc_done_flag;

   // Status
   logic                      busy;

   modport slave (
      input  req, req_valid, req_data, core_data_read_flag, core_calc_done_flag,
      output grant, req_ack, done, err, core_reset, core_data_in_flag,
             core_data_in, busy
   );

   modport master (
      output req, req_valid, req_data, core_data_read_flag, core_calc_done_flag,
      input  grant, req_ack, done, err, core_reset, core_data_in_flag,
             core_data_in, busy
   );
endinterface

// File: rtl/ndp_core_arbiter.sv
// Round-robin arbiter that time-shares one NDP core between NUM_REQ
// requesters. Each job: reset the core, stream the owner's words into it,
// wait for the calculation, then pulse done (or err on timeout).
// The interface instance must use the same NUM_REQ/DATA_W as this module.
module ndp_core_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 32,
   parameter int RST_CYC     = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              reset,
   ndp_core_arbiter_if.slave bus
);

   localparam int OWN_W = $clog2(NUM_REQ);
   localparam int CNT_W = 16;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [OWN_W-1:0] OWN_LAST = OWN_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CORE_RST,
      S_LOAD,
      S_WAIT_CALC,
      S_FINISH
   } state_e;

   state_e             state_q,      state_d;
   logic [NUM_REQ-1:0] grant_q,      grant_d;
   logic [OWN_W-1:0]   owner_q,      owner_d;
   logic [OWN_W-1:0]   last_owner_q, last_owner_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic               seen_read_q,  seen_read_d;

   logic               pick_found;
   logic [OWN_W-1:0]   pick_idx;
   logic               timeout_hit;
   logic               own_valid;
   logic [DATA_W-1:0]  own_data;

   // Round-robin pick: first requester at or after last_owner+1, with wrap.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!pick_found && bus.req[j] &&
                ((int'(last_owner_q) + k) % NUM_REQ) == j) begin
               pick_found = 1'b1;
               pick_idx   = OWN_W'(j);
            end
         end
      end
   end

   // Next-state logic for the job sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      seen_read_d  = seen_read_q;
      timeout_hit  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               state_d           = S_CORE_RST;
               owner_d           = pick_idx;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               cnt_d             = '0;
            end
         end

         S_CORE_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d     = S_LOAD;
               cnt_d       = '0;
               seen_read_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_LOAD: begin
            // The stream ends when the core stops reading after having read.
            if (bus.core_data_read_flag) begin
               seen_read_d = 1'b1;
            end else if (seen_read_q) begin
               if (bus.core_calc_done_flag) begin
                  state_d      = S_FINISH;
                  last_owner_d = owner_q;
               end else begin
                  state_d = S_WAIT_CALC;
                  cnt_d   = '0;
               end
            end
         end

         S_WAIT_CALC: begin
            if (bus.core_calc_done_flag) begin
               state_d      = S_FINISH;
               last_owner_d = owner_q;
            end else if (cnt_q == TMO_LAST) begin
               // Abort: err is raised this cycle, grant drops with IDLE.
               timeout_hit  = 1'b1;
               state_d      = S_IDLE;
               grant_d      = '0;
               last_owner_d = owner_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
            grant_d = '0;
         end

         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State and bookkeeping registers; reset aborts any job silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_owner_q <= OWN_LAST;
         cnt_q        <= '0;
         seen_read_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         seen_read_q  <= seen_read_d;
      end
   end

   // Steer the owner's stream word and valid toward the core.
   always_comb begin
      own_valid = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            own_valid = bus.req_valid[i];
            own_data  = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.grant             = grant_q;
   assign bus.req_ack           = grant_q & {NUM_REQ{bus.core_data_read_flag}};
   assign bus.done              = (state_q == S_FINISH) ? grant_q : '0;
   assign bus.err               = timeout_hit ? grant_q : '0;
   // The core is held in reset whenever no job is loading or computing.
   assign bus.core_reset        = (state_q == S_IDLE) || (state_q == S_CORE_RST);
   assign bus.core_data_in_flag = (state_q == S_LOAD) && own_valid;
   assign bus.core_data_in      = own_data;
   assign bus.busy              = (state_q != S_IDLE);

endmodule

// File: doc/ndp_core_arbiter.md
NDP_CORE_ARBITER -- requirements
Module: ndp_core_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one NDP core (2..8).
REQ-002 SHALL have parameter DATA_W, default 32: stream word width, equal to the core data_in width.
REQ-003 SHALL have parameter RST_CYC, default 2: number of cycles the core reset is held per job (1..15).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096: cycle limit in WAIT_CALC before an abort (2..65535).
REQ-005 clk  in  1  single clock for the block; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-007 req  in  NUM_REQ  per-requester job request level.
REQ-008 req_valid  in  NUM_REQ  per-requester stream word valid.
REQ-009 req_data  in  NUM_REQ*DATA_W  per-requester stream words; slice i belongs to requester i.
REQ-010 grant  out  NUM_REQ  one-hot owner of the core; all zero when idle.
REQ-011 req_ack  out  NUM_REQ  combinational: grant[i] AND core_data_read_flag.
REQ-012 done  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-013 err  out  NUM_REQ  one-cycle timeout-abort pulse to the owner.
REQ-014 core_reset  out  1  active-high synchronous reset driven to the NDP core.
REQ-015 core_data_in_flag  out  1  combinational: req_valid of the owner when in LOAD, else 0.
REQ-016 core_data_in  out  DATA_W  combinational: req_data slice of the owner; 0 when no owner.
REQ-017 core_data_read_flag  in  1  core is accepting stream words.
REQ-018 core_calc_done_flag  in  1  core calculation complete.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, CORE_RST, LOAD, WAIT_CALC, FINISH.
REQ-021 IDLE: if req is nonzero, SHALL pick the owner by round-robin, searching from index (last_owner+1) mod NUM_REQ upward with wrap; register grant; go to CORE_RST next cycle.
REQ-022 Round-robin pointer last_owner SHALL update only on entry to FINISH or on abort, and SHALL reset to NUM_REQ-1 so requester 0 wins first.
REQ-023 CORE_RST: core_reset SHALL be 1 for exactly RST_CYC cycles, then 0; go to LOAD.
REQ-024 LOAD: the block SHALL set flag seen_read when core_data_read_flag=1; on core_data_read_flag falling to 0 with seen_read=1, go to WAIT_CALC.
REQ-025 LOAD: core_data_read_flag=0 with core_calc_done_flag=1 and seen_read=1 in the same cycle SHALL go directly to FINISH.
REQ-026 WAIT_CALC: on core_calc_done_flag=1, go to FINISH; the cycle counter SHALL clear on entry and increment each cycle; reaching TIMEOUT_CYC-1 without done SHALL pulse err[owner] and go to IDLE with grant cleared.
REQ-027 FINISH: done[owner] SHALL be 1 for exactly one cycle; grant SHALL drop on the next cycle; return to IDLE.
REQ-028 Owner's req deassertion after grant SHALL be ignored; the job runs to FINISH or abort.
REQ-029 Non-owner req/req_valid SHALL have no effect on core outputs and SHALL receive req_ack=0.
REQ-030 A requester holding req high through FINISH SHALL NOT be re-granted before any other pending requester.
REQ-031 Minimum IDLE dwell between jobs SHALL be 1 cycle.

Reset
REQ-032 On reset=0: state IDLE, grant=0, done=0, err=0, busy=0, core_reset=1, counter=0, seen_read=0, last_owner=NUM_REQ-1.
REQ-033 core_reset SHALL stay 1 while in IDLE so the core is held idle between jobs.
REQ-034 Reset asserted mid-job SHALL abort silently: no done or err pulse.

Verification
REQ-035 req=0001, core asserts read for 10 cycles then drops, calc_done 20 cycles later -> grant=0001, core_reset high 2 cycles, 10 req_ack cycles, done[0] single pulse.
REQ-036 req=1111 held, each job completes -> grant sequence 0001,0010,0100,1000,0001.
REQ-037 Owner 2 deasserts req during LOAD -> job continues, done[2] pulses, no other grant meanwhile.
REQ-038 TIMEOUT_CYC=16, calc_done never asserted -> err[owner] pulses 16 cycles after WAIT_CALC entry, busy=0 next cycle.
REQ-039 Read-flag fall and calc_done in the same cycle -> FINISH next cycle, WAIT_CALC skipped.
REQ-040 reset=0 during LOAD -> outputs at REQ-032 values asynchronously, no done/err, next req restarts from requester 0.
